subscripts_gen_pipe: RTL and testbench

// - Parametrised, pipelined successor of the combinational subscript generator in the access unit.
// - Computes per subscript s: sub[s] = base[s] + sum_j(iv[s][j] * stride[s][j]), unsigned.
// - Strides and bases come from internal config registers.
// - Two-stage valid/ready pipeline between the loop-IV generator and the flat-address / bank-select logic.

---
 rtl/subscripts_gen_pipe.sv | 145 ++++++++++++++
 tb/tb_subscripts_gen_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/subscripts_gen_pipe.sv
// Two-stage subscript generator: sub[s] = base[s] + sum_j iv[s][j]*stride[s][j].
// Optional bound wrap against per-subscript limits: SUBSCRIPTS_GEN_BOUND_WRAP_EN.
module subscripts_gen_pipe #(
  parameter int N_SUB  = 2,
  parameter int N_IV   = 4,
  parameter int IV_W   = 8,
  parameter int ADDR_W = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cfg_we_i,
  input  logic [N_SUB*N_IV*IV_W-1:0]   cfg_stride_i,
  input  logic [N_SUB*ADDR_W-1:0]      cfg_base_i,
  input  logic [N_SUB*ADDR_W-1:0]      cfg_limit_i,
  output logic                         busy_o,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [N_SUB*N_IV*IV_W-1:0]   iv_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [N_SUB*ADDR_W-1:0]      subscripts_o,
  output logic [N_SUB-1:0]             oob_o
);

  localparam int PW = (2*IV_W > ADDR_W) ? 2*IV_W : ADDR_W;

  logic [N_SUB*N_IV*IV_W-1:0] r_stride;
  logic [N_SUB*ADDR_W-1:0]    r_base;
  logic [ADDR_W-1:0]          r_prod [N_SUB][N_IV];
  logic                       r_s1_valid;
  logic                       r_out_valid;
  logic [N_SUB*ADDR_W-1:0]    r_sub;
  logic [N_SUB-1:0]           r_oob;

  logic                       w_adv;
  logic                       w_xfer;
  logic                       w_cfg_ld;
  logic [ADDR_W-1:0]          w_prod [N_SUB][N_IV];
  logic [ADDR_W-1:0]          w_v;
  logic [N_SUB*ADDR_W-1:0]    w_sub;
  logic [N_SUB-1:0]           w_oob;

`ifdef SUBSCRIPTS_GEN_BOUND_WRAP_EN
  logic [N_SUB*ADDR_W-1:0]    r_limit;
  logic [ADDR_W-1:0]          w_lim;
`else
  logic                       w_unused_limit;
  assign w_unused_limit = ^cfg_limit_i;
`endif

  function automatic logic [ADDR_W-1:0] mul_tr(
    input logic [IV_W-1:0] a,
    input logic [IV_W-1:0] b
  );
    logic [PW-1:0] f;
    f = PW'(a) * PW'(b);
    return f[ADDR_W-1:0];
  endfunction

  assign busy_o      = r_s1_valid | r_out_valid;
  assign w_adv       = !r_out_valid | out_ready_i;
  assign in_ready_o  = w_adv & !cfg_we_i;
  assign w_xfer      = in_valid_i & in_ready_o;
  assign w_cfg_ld    = cfg_we_i & !busy_o;
  assign out_valid_o = r_out_valid;
  assign subscripts_o = r_sub;
  assign oob_o       = r_oob;

  always_comb begin
    for (int s = 0; s < N_SUB; s++) begin
      for (int j = 0; j < N_IV; j++) begin
        w_prod[s][j] = mul_tr(iv_i[(s*N_IV+j)*IV_W +: IV_W],
                              r_stride[(s*N_IV+j)*IV_W +: IV_W]);
      end
    end
  end

  // Sum wraps silently; the optional bound check is a single subtraction.
  always_comb begin
    w_sub = '0;
    w_oob = '0;
    w_v   = '0;
`ifdef SUBSCRIPTS_GEN_BOUND_WRAP_EN
    w_lim = '0;
`endif
    for (int s = 0; s < N_SUB; s++) begin
      w_v = r_base[s*ADDR_W +: ADDR_W];
      for (int j = 0; j < N_IV; j++) begin
        w_v = w_v + r_prod[s][j];
      end
`ifdef SUBSCRIPTS_GEN_BOUND_WRAP_EN
      w_lim = r_limit[s*ADDR_W +: ADDR_W];
      if (w_lim != '0 && w_v >= w_lim) begin
        w_sub[s*ADDR_W +: ADDR_W] = w_v - w_lim;
        w_oob[s] = 1'b1;
      end else begin
        w_sub[s*ADDR_W +: ADDR_W] = w_v;
      end
`else
      w_sub[s*ADDR_W +: ADDR_W] = w_v;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stride    <= '0;
      r_base      <= '0;
`ifdef SUBSCRIPTS_GEN_BOUND_WRAP_EN
      r_limit     <= '0;
`endif
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_sub       <= '0;
      r_oob       <= '0;
      for (int s = 0; s < N_SUB; s++) begin
        for (int j = 0; j < N_IV; j++) begin
          r_prod[s][j] <= '0;
        end
      end
    end else begin
      if (w_cfg_ld) begin
        r_stride <= cfg_stride_i;
        r_base   <= cfg_base_i;
`ifdef SUBSCRIPTS_GEN_BOUND_WRAP_EN
        r_limit  <= cfg_limit_i;
`endif
      end
      if (w_adv) begin
        r_s1_valid  <= w_xfer;
        r_out_valid <= r_s1_valid;
        r_sub       <= w_sub;
        r_oob       <= w_oob;
        if (w_xfer) begin
          for (int s = 0; s < N_SUB; s++) begin
            for (int j = 0; j < N_IV; j++) begin
              r_prod[s][j] <= w_prod[s][j];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_subscripts_gen_pipe.sv
// Scoreboard bench for subscripts_gen_pipe.
// Bound-wrap checks run when SUBSCRIPTS_GEN_BOUND_WRAP_EN is defined.
module tb_subscripts_gen_pipe;
  localparam int N_SUB  = 2;
  localparam int N_IV   = 4;
  localparam int IV_W   = 8;
  localparam int ADDR_W = 16;
  localparam int VW     = N_SUB*N_IV*IV_W;
  localparam int SW     = N_SUB*ADDR_W;
  localparam int MASK   = (1 << ADDR_W) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          cfg_we_i = 1'b0;
  logic [VW-1:0] cfg_stride_i = '0;
  logic [SW-1:0] cfg_base_i = '0;
  logic [SW-1:0] cfg_limit_i = '0;
  logic          busy_o;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [VW-1:0] iv_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b1;
  logic [SW-1:0] subscripts_o;
  logic [N_SUB-1:0] oob_o;

  subscripts_gen_pipe #(
    .N_SUB(N_SUB), .N_IV(N_IV), .IV_W(IV_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_we_i(cfg_we_i),
    .cfg_stride_i(cfg_stride_i), .cfg_base_i(cfg_base_i),
    .cfg_limit_i(cfg_limit_i), .busy_o(busy_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .iv_i(iv_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .subscripts_o(subscripts_o), .oob_o(oob_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int m_stride [N_SUB][N_IV];
  int m_base   [N_SUB];
  int m_limit  [N_SUB];
  logic [SW+N_SUB-1:0] q[$];

  function automatic logic [SW+N_SUB-1:0] model(input logic [VW-1:0] v);
    logic [SW-1:0]    subs;
    logic [N_SUB-1:0] oob;
    subs = '0;
    oob  = '0;
    for (int s = 0; s < N_SUB; s++) begin
      int acc;
      acc = m_base[s];
      for (int j = 0; j < N_IV; j++) begin
        acc += (int'(v[(s*N_IV+j)*IV_W +: IV_W]) * m_stride[s][j]) & MASK;
      end
      acc = acc & MASK;
`ifdef SUBSCRIPTS_GEN_BOUND_WRAP_EN
      if (m_limit[s] != 0 && acc >= m_limit[s]) begin
        acc = acc - m_limit[s];
        oob[s] = 1'b1;
      end
`endif
      subs[s*ADDR_W +: ADDR_W] = acc[ADDR_W-1:0];
    end
    return {oob, subs};
  endfunction

  // Inputs are stable at the falling edge, so decide what the next edge does.
  always @(negedge clk_i) begin
    if (rst_i) begin
      q.delete();
      for (int s = 0; s < N_SUB; s++) begin
        m_base[s]  = 0;
        m_limit[s] = 0;
        for (int j = 0; j < N_IV; j++) m_stride[s][j] = 0;
      end
    end else begin
      if (out_valid_o && q.size() == 0) begin
        chk("spurious_out", 1'b1, 1'b0);
      end else if (out_valid_o && out_ready_i) begin
        logic [SW+N_SUB-1:0] e;
        e = q.pop_front();
        n_out++;
        chk("sub", subscripts_o, e[SW-1:0]);
        chk("oob", oob_o, e[SW +: N_SUB]);
      end else if (out_valid_o) begin
        chk("stall_sub", subscripts_o, q[0][SW-1:0]);
      end
      if (cfg_we_i && !busy_o) begin
        for (int s = 0; s < N_SUB; s++) begin
          m_base[s]  = int'(cfg_base_i[s*ADDR_W +: ADDR_W]);
          m_limit[s] = int'(cfg_limit_i[s*ADDR_W +: ADDR_W]);
          for (int j = 0; j < N_IV; j++)
            m_stride[s][j] = int'(cfg_stride_i[(s*N_IV+j)*IV_W +: IV_W]);
        end
      end
      if (in_valid_i && in_ready_o) q.push_back(model(iv_i));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_iv(input int s, input int j, input int v);
    iv_i[(s*N_IV+j)*IV_W +: IV_W] = IV_W'(v);
  endtask

  task automatic set_st(input int s, input int j, input int v);
    cfg_stride_i[(s*N_IV+j)*IV_W +: IV_W] = IV_W'(v);
  endtask

  task automatic send(input logic [VW-1:0] v);
    bit ok;
    ok = 1'b0;
    in_valid_i = 1'b1;
    iv_i = v;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 1'b0, 1'b1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (!busy_o && q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) chk("drain_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_cfg();
    cfg_we_i = 1'b1;
    step();
    cfg_we_i = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_sub", subscripts_o, '0);
    chk("rst_oob", oob_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", in_ready_o, 1'b1);
    rst_i = 1'b0;
    step();

    in_valid_i = 1'b1;
    iv_i = {VW{1'b1}};
    step();
    in_valid_i = 1'b0;
    chk("lat1_valid", out_valid_o, 1'b0);
    chk("lat1_busy", busy_o, 1'b1);
    step();
    chk("lat2_valid", out_valid_o, 1'b1);
    chk("lat2_sub", subscripts_o, '0);
    drain();

    set_st(0, 0, 1); set_st(0, 1, 4); set_st(0, 2, 0); set_st(0, 3, 0);
    set_st(1, 0, 2); set_st(1, 1, 0); set_st(1, 2, 0); set_st(1, 3, 3);
    cfg_base_i = {16'd0, 16'd10};
    set_iv(0, 0, 3); set_iv(0, 1, 2); set_iv(0, 2, 7); set_iv(0, 3, 9);
    set_iv(1, 0, 5); set_iv(1, 1, 6); set_iv(1, 2, 11); set_iv(1, 3, 1);
    cfg_we_i = 1'b1;
    in_valid_i = 1'b1;
    #1;
    chk("cfg_blocks_in", in_ready_o, 1'b0);
    step();
    cfg_we_i = 1'b0;
    step();
    in_valid_i = 1'b0;
    step();
    chk("cfg_out_valid", out_valid_o, 1'b1);
    chk("cfg_sub", subscripts_o, {16'd13, 16'd21});
    drain();

    send(iv_i);
    chk("busy_cfg", busy_o, 1'b1);
    for (int s = 0; s < N_SUB; s++)
      for (int j = 0; j < N_IV; j++) set_st(s, j, 1);
    do_cfg();
    drain();
    send(iv_i);
    step();
    chk("cfg_ignored", subscripts_o, {16'd13, 16'd21});
    drain();

    fork
      begin
        for (int n = 0; n < 8; n++) send(VW'({$urandom, $urandom}));
      end
      begin
        repeat (4) step();
        out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk_i);
          chk("stall_valid", out_valid_o, 1'b1);
          @(posedge clk_i);
          #1;
        end
        out_ready_i = 1'b1;
      end
    join
    drain();

    for (int s = 0; s < N_SUB; s++)
      for (int j = 0; j < N_IV; j++) set_st(s, j, 255);
    cfg_base_i = {16'hFFFF, 16'hFFFF};
    do_cfg();
    send({VW{1'b1}});
    step();
    chk("ovf_sub", subscripts_o, {16'hF803, 16'hF803});
    chk("ovf_oob", oob_o, '0);
    drain();

    send({VW{1'b1}});
    rst_i = 1'b1;
    step();
    chk("midrst_valid", out_valid_o, 1'b0);
    chk("midrst_busy", busy_o, 1'b0);
    rst_i = 1'b0;
    send({VW{1'b1}});
    step();
    chk("midrst_cfg", subscripts_o, '0);
    drain();

`ifdef SUBSCRIPTS_GEN_BOUND_WRAP_EN
    cfg_stride_i = '0;
    set_st(0, 0, 1);
    set_st(1, 0, 1);
    cfg_base_i = '0;
    cfg_limit_i = {16'd0, 16'd100};
    do_cfg();
    iv_i = '0;
    set_iv(0, 0, 130);
    set_iv(1, 0, 130);
    send(iv_i);
    step();
    chk("wrap_sub", subscripts_o, {16'd130, 16'd30});
    chk("wrap_oob", oob_o, 2'b01);
    drain();
`endif

    chk("out_count_min", n_out >= 14, 1'b1);
    chk("q_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
